// File: rtl/pipelined_adder_n.sv
// N-bit add/subtract cut into STAGES carry-chained chunks, one register level
// per chunk, with valid/ready handshakes on both the operand and result sides.
module pipelined_adder_n #(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    localparam int W    = N / STAGES;
    localparam int LAST = STAGES - 1;

    // src_* is what stage k consumes: the ports for stage 0, else stage k-1's registers
    logic [N-1:0] src_a [STAGES];
    logic [N-1:0] src_b [STAGES];
    logic [N-1:0] src_s [STAGES];
    logic         src_c [STAGES];
    logic         src_v [STAGES];

    logic [N-1:0] a_d [STAGES];
    logic [N-1:0] a_q [STAGES];
    logic [N-1:0] b_d [STAGES];
    logic [N-1:0] b_q [STAGES];
    logic [N-1:0] s_d [STAGES];
    logic [N-1:0] s_q [STAGES];
    logic         c_d [STAGES];
    logic         c_q [STAGES];
    logic         v_d [STAGES];
    logic         v_q [STAGES];
    logic         ovf_d;
    logic         ovf_q;
    logic         advance;

    // The whole pipe moves as one; it only freezes when a result is waiting unclaimed
    assign advance   = out_ready || !v_q[LAST];
    assign in_ready  = advance;
    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [W:0] part;

        if (gi == 0) begin : g_head
            // Subtract is a + ~b + ~cin, so invert both once at the entrance
            assign src_a[gi] = a;
            assign src_b[gi] = sub ? ~b : b;
            assign src_c[gi] = sub ? ~cin : cin;
            assign src_v[gi] = in_valid && advance;
            assign src_s[gi] = '0;
        end else begin : g_link
            assign src_a[gi] = a_q[gi-1];
            assign src_b[gi] = b_q[gi-1];
            assign src_c[gi] = c_q[gi-1];
            assign src_v[gi] = v_q[gi-1];
            assign src_s[gi] = s_q[gi-1];
        end

        always_comb begin
            part    = {1'b0, src_a[gi][gi*W +: W]} + {1'b0, src_b[gi][gi*W +: W]}
                    + (W+1)'(src_c[gi]);
            a_d[gi] = src_a[gi];
            b_d[gi] = src_b[gi];
            s_d[gi] = src_s[gi];
            s_d[gi][gi*W +: W] = part[W-1:0];
            c_d[gi] = part[W];
            v_d[gi] = src_v[gi];
        end
    end

    always_comb begin
        ovf_d = (src_a[LAST][N-1] == src_b[LAST][N-1]) &&
                (s_d[LAST][N-1] != src_a[LAST][N-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                s_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                c_q[k] <= c_d[k];
                s_q[k] <= s_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

endmodule
